// File: rtl/fifo_vec_assembler_pkg.sv
// Shared GPU constants: FIFO word width and vector geometry.
// Used by the DRAM read path, the vector assembler and the vector datapath.
package gpu_pkg;

  localparam int WORD_W    = 32;
  localparam int VEC_SHIFT = 2;
  localparam int VEC_WORDS = 1 << VEC_SHIFT;
  localparam int CNT_W     = 30;

  typedef logic [WORD_W-1:0]           word_t;
  typedef logic [WORD_W*VEC_WORDS-1:0] vec_t;

endpackage

// File: rtl/fifo_vec_assembler_if.sv
// FIFO read side and vector output handshake of the assembler.
// master: assembler side; slave: FIFO / downstream datapath side.
interface fifo_vec_assembler_if;
  import gpu_pkg::*;

  logic  fifo_rdreq;
  word_t fifo_q;
  logic  fifo_empty;
  vec_t  vec_data;
  logic  vec_valid;
  logic  vec_ready;

  modport master (
    output fifo_rdreq,
    input  fifo_q,
    input  fifo_empty,
    output vec_data,
    output vec_valid,
    input  vec_ready
  );

  modport slave (
    input  fifo_rdreq,
    output fifo_q,
    output fifo_empty,
    input  vec_data,
    input  vec_valid,
    output vec_ready
  );

endinterface

// File: rtl/fifo_vec_assembler_vec_out_reg.sv
// Single-entry valid/ready holding register for assembled vectors.
// load_i/data_i in, ready_o = may load, data_o/valid_o out, xfer_o = handoff.
module vec_out_reg
  import gpu_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  vec_t data_i,
  output logic ready_o,
  output vec_t data_o,
  output logic valid_o,
  input  logic dst_ready_i,
  output logic xfer_o
);

  logic valid_q;
  vec_t data_q;

  assign ready_o = !valid_q || dst_ready_i;
  assign xfer_o  = valid_q && dst_ready_i;
  assign data_o  = data_q;
  assign valid_o = valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end else if (xfer_o) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_vec_assembler.sv
// Pops a non-show-ahead FIFO and packs VEC_WORDS words per output vector.
// Ports: clk, rst_n, start/num_vectors job control, busy/done, bus (FIFO+vector).
module fifo_vec_assembler #(
  parameter int WORD_W    = gpu_pkg::WORD_W,
  parameter int VEC_SHIFT = gpu_pkg::VEC_SHIFT,
  parameter int CNT_W     = gpu_pkg::CNT_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [CNT_W-1:0]            num_vectors,
  output logic                        busy,
  output logic                        done,
  fifo_vec_assembler_if.master        bus
);

  localparam int VEC_WORDS = 1 << VEC_SHIFT;
  localparam int WCNT_W    = CNT_W + VEC_SHIFT;
  localparam int ACNT_W    = VEC_SHIFT + 1;
  localparam int SUM_W     = ACNT_W + 1;

  logic                       busy_q;
  logic                       done_q;
  logic                       inflight_q;
  logic [WCNT_W-1:0]          words_left_q;
  logic [CNT_W-1:0]           vec_left_q;
  logic [ACNT_W-1:0]          asm_cnt_q;
  logic [WORD_W-1:0]          lanes_q [VEC_WORDS];
  logic [WORD_W*VEC_WORDS-1:0] lanes_flat;

  logic pop;
  logic full;
  logic load;
  logic out_rdy;
  logic xfer;
  logic [SUM_W-1:0] occ;

  // Lanes already filled plus the word still in the FIFO pipeline.
  assign occ  = SUM_W'(asm_cnt_q) + SUM_W'(inflight_q);
  assign pop  = busy_q && (words_left_q != '0) &&
                !bus.fifo_empty && (occ < SUM_W'(VEC_WORDS));
  assign full = (asm_cnt_q == ACNT_W'(VEC_WORDS));
  assign load = full && out_rdy;

  assign bus.fifo_rdreq = pop;
  assign busy = busy_q;
  assign done = done_q;

  always_comb begin
    lanes_flat = '0;
    for (int i = 0; i < VEC_WORDS; i++) begin
      lanes_flat[i*WORD_W +: WORD_W] = lanes_q[i];
    end
  end

  vec_out_reg u_out (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (load),
    .data_i      (lanes_flat),
    .ready_o     (out_rdy),
    .data_o      (bus.vec_data),
    .valid_o     (bus.vec_valid),
    .dst_ready_i (bus.vec_ready),
    .xfer_o      (xfer)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q       <= 1'b0;
      done_q       <= 1'b1;
      inflight_q   <= 1'b0;
      words_left_q <= '0;
      vec_left_q   <= '0;
      asm_cnt_q    <= '0;
      for (int i = 0; i < VEC_WORDS; i++) begin
        lanes_q[i] <= '0;
      end
    end else begin
      inflight_q <= pop;

      if (start && !busy_q) begin
        words_left_q <= WCNT_W'(num_vectors) << VEC_SHIFT;
        vec_left_q   <= num_vectors;
        busy_q       <= (num_vectors != '0);
        done_q       <= (num_vectors == '0);
      end else begin
        if (pop) begin
          words_left_q <= words_left_q - WCNT_W'(1);
        end
        if (xfer && (vec_left_q != '0)) begin
          vec_left_q <= vec_left_q - CNT_W'(1);
          if (vec_left_q == CNT_W'(1)) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
      end

      // FIFO data lands one cycle after the pop.
      if (inflight_q) begin
        lanes_q[asm_cnt_q[VEC_SHIFT-1:0]] <= bus.fifo_q;
      end

      // Pop rule keeps capture and load from coinciding.
      if (load) begin
        asm_cnt_q <= '0;
      end else if (inflight_q) begin
        asm_cnt_q <= asm_cnt_q + ACNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_vec_assembler.sv
// Scoreboard bench for fifo_vec_assembler with a FIFO model.
// Expected vectors come from the ordered word stream, grouped per job.
module tb_fifo_vec_assembler;
  import gpu_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_vectors = '0;
  logic             busy;
  logic             done;

  fifo_vec_assembler_if bus ();

  fifo_vec_assembler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .num_vectors (num_vectors),
    .busy        (busy),
    .done        (done),
    .bus         (bus.master)
  );

  always #5 clk = ~clk;

  logic [31:0] fifo_m[$];
  logic [31:0] pend_q[$];
  logic [31:0] stage_q[$];
  logic [31:0] stream_q[$];
  vec_t        exp_q[$];

  int compared = 0;
  int mismatched = 0;
  int pops = 0;
  bit hold_empty = 0;
  bit rnd = 0;

  // FIFO: non-show-ahead, 1-cycle read latency.
  always @(posedge clk) begin
    if (bus.fifo_rdreq === 1'b1) begin
      compared++;
      if (fifo_m.size() == 0) begin
        mismatched++;
        $display("FAIL rdreq_on_empty: rdreq=1 with empty fifo");
      end else begin
        bus.fifo_q <= fifo_m.pop_front();
        pops++;
      end
    end
    while (pend_q.size() > 0) fifo_m.push_back(pend_q.pop_front());
    bus.fifo_empty <= (fifo_m.size() == 0) || hold_empty;
  end

  vec_t last_data;
  vec_t e;
  bit   last_stall = 0;

  // Monitor: compare every handed-off vector; check hold stability.
  always @(negedge clk) begin
    if (rst_n) begin
      if (last_stall) begin
        compared++;
        if (bus.vec_valid !== 1'b1 || bus.vec_data !== last_data) begin
          mismatched++;
          $display("FAIL hold_stable: valid=%b data=%h required %h",
                   bus.vec_valid, bus.vec_data, last_data);
        end
      end
      if (bus.vec_valid === 1'b1 && bus.vec_ready === 1'b1) begin
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_vec: got %h, none expected",
                   bus.vec_data);
        end else begin
          e = exp_q.pop_front();
          if (bus.vec_data !== e) begin
            mismatched++;
            $display("FAIL vec_data: got %h required %h",
                     bus.vec_data, e);
          end
        end
      end
      last_stall = (bus.vec_valid === 1'b1) && (bus.vec_ready !== 1'b1);
      last_data  = bus.vec_data;
    end else begin
      last_stall = 0;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd) begin
        hold_empty    = ($urandom_range(0, 3) == 0);
        bus.vec_ready = ($urandom_range(0, 2) != 0);
      end
    end
  end

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic gen_word(input logic [31:0] w);
    stream_q.push_back(w);
    stage_q.push_back(w);
  endtask

  task automatic gen(input int n);
    for (int i = 0; i < n; i++) gen_word($urandom);
  endtask

  task automatic rel(input int n);
    for (int i = 0; i < n; i++) begin
      if (stage_q.size() > 0) pend_q.push_back(stage_q.pop_front());
    end
  endtask

  task automatic do_start(input int n);
    vec_t v;
    @(posedge clk);
    #1;
    if (busy === 1'b0) begin
      for (int k = 0; k < n; k++) begin
        v = '0;
        for (int w = 0; w < VEC_WORDS; w++) begin
          v[w*WORD_W +: WORD_W] = stream_q.pop_front();
        end
        exp_q.push_back(v);
      end
    end
    start = 1'b1;
    num_vectors = CNT_W'(n);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k;
    k = 0;
    while (!(done === 1'b1 && exp_q.size() == 0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    compared++;
    if (k >= budget) begin
      mismatched++;
      $display("FAIL %s_timeout: done=%b pending=%0d after %0d cycles",
               name, done, exp_q.size(), k);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_done"}, done, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_valid"}, bus.vec_valid, 0);
    check({tag, "_rdreq"}, bus.fifo_rdreq, 0);
    check({tag, "_data0"}, |bus.vec_data, 0);
  endtask

  int p0;
  int k;
  int n;

  initial begin
    bus.vec_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outs("rst");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Single vector, fixed words, latency check.
    gen_word(32'h11);
    gen_word(32'h22);
    gen_word(32'h33);
    gen_word(32'h44);
    rel(4);
    repeat (2) @(posedge clk);
    p0 = pops;
    do_start(1);
    @(negedge clk);
    check("t1_first_pop", bus.fifo_rdreq, 1);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (bus.vec_valid !== 1'b1 && k < 20);
    check("t1_latency", k, 6);
    check("t1_vec", bus.vec_data[63:0], 64'h00000022_00000011);
    wait_done("t1", 100);
    check("t1_pops", pops - p0, 4);
    check("t1_done", done, 1);

    // Two vectors, extra words stay in FIFO.
    gen(12);
    rel(12);
    repeat (2) @(posedge clk);
    p0 = pops;
    do_start(2);
    wait_done("t2", 100);
    check("t2_pops", pops - p0, 8);
    check("t2_left", fifo_m.size(), 4);

    // Backpressure.
    gen(8);
    rel(8);
    bus.vec_ready = 1'b0;
    p0 = pops;
    do_start(3);
    repeat (20) @(posedge clk);
    #1;
    check("t3_held_pops", pops - p0, 8);
    check("t3_valid_held", bus.vec_valid, 1);
    bus.vec_ready = 1'b1;
    wait_done("t3", 100);
    check("t3_pops", pops - p0, 12);
    check("t3_left", fifo_m.size(), 0);

    // FIFO runs dry after two words.
    gen(4);
    rel(2);
    p0 = pops;
    do_start(1);
    repeat (8) @(posedge clk);
    #1;
    check("t4_pops_stalled", pops - p0, 2);
    check("t4_rdreq_idle", bus.fifo_rdreq, 0);
    check("t4_no_valid", bus.vec_valid, 0);
    rel(2);
    wait_done("t4", 100);
    check("t4_pops", pops - p0, 4);

    // Zero-length job.
    p0 = pops;
    do_start(0);
    repeat (5) @(posedge clk);
    #1;
    check("t5_pops", pops - p0, 0);
    check("t5_done", done, 1);
    check("t5_busy", busy, 0);

    // Start while busy is ignored.
    gen(8);
    rel(8);
    p0 = pops;
    do_start(2);
    repeat (3) @(posedge clk);
    do_start(5);
    wait_done("t6", 150);
    check("t6_pops", pops - p0, 8);

    // Random jobs with FIFO stalls and backpressure.
    rnd = 1;
    for (int j = 0; j < 8; j++) begin
      n = $urandom_range(1, 4);
      gen(n * VEC_WORDS + $urandom_range(0, 3));
      rel(stage_q.size());
      p0 = pops;
      do_start(n);
      wait_done("rand", 600);
      check("rand_pops", pops - p0, n * VEC_WORDS);
    end
    rnd = 0;
    @(posedge clk);
    #1;
    hold_empty = 0;
    bus.vec_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rand_stream_left", fifo_m.size() + pend_q.size(),
          stream_q.size());

    // Reset mid-job with lanes partly filled.
    gen(8);
    rel(8);
    repeat (2) @(posedge clk);
    p0 = pops;
    do_start(2);
    k = 0;
    while (pops - p0 < 3 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("t7_reached_pops", (pops - p0 >= 3), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outs("t7_rst");
    fifo_m.delete();
    pend_q.delete();
    stage_q.delete();
    stream_q.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    gen(4);
    rel(4);
    repeat (2) @(posedge clk);
    p0 = pops;
    do_start(1);
    wait_done("t7", 100);
    check("t7_pops", pops - p0, 4);
    check("t7_left", fifo_m.size(), 0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
